// File: rtl/hex_block_assembler.sv
// hex_block_assembler: packs an ASCII hex character stream MSB-first into 4*NIBBLES-bit blocks.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   char_in, char_valid   ASCII character stream in; char_ready accepts it (registered)
//   block_out             accumulator, valid while block_valid is high
//   block_valid/ready     completed-block handshake
//   err                   one-cycle pulse after an illegal character discards the partial block
//   nib_cnt               digits collected in the current block
// Build option: define HEX_ASM_UPPERCASE_EN to accept 'A'-'F' as digits; otherwise they are illegal.
module hex_block_assembler #(
    parameter int NIBBLES = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   char_in,
    input  logic                         char_valid,
    output logic                         char_ready,
    output logic [4*NIBBLES-1:0]         block_out,
    output logic                         block_valid,
    input  logic                         block_ready,
    output logic                         err,
    output logic [$clog2(NIBBLES+1)-1:0] nib_cnt
);
    localparam int W = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic {COLLECT, HOLD} state_t;
    state_t state;

    logic is_dec, is_low, is_up, is_dig, is_ws, take;
    logic [3:0] nibble;

    assign is_dec = char_in >= 8'h30 && char_in <= 8'h39;
    assign is_low = char_in >= 8'h61 && char_in <= 8'h66;
`ifdef HEX_ASM_UPPERCASE_EN
    assign is_up = char_in >= 8'h41 && char_in <= 8'h46;
`else
    assign is_up = 1'b0;
`endif
    assign is_dig = is_dec || is_low || is_up;
    assign is_ws = char_in == 8'h20 || char_in == 8'h09 || char_in == 8'h0a || char_in == 8'h0d;
    // Letters 'a'/'A' have low nibble 1, so adding 9 yields 10..15.
    assign nibble = is_dec ? char_in[3:0] : char_in[3:0] + 4'd9;
    // char_ready is only ever high in COLLECT, so this is the accepted transfer.
    assign take = char_valid && char_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            block_out   <= '0;
            nib_cnt     <= '0;
            char_ready  <= 1'b0;
            block_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == COLLECT) begin
                char_ready <= 1'b1;
                if (take && is_dig) begin
                    block_out <= {block_out[W-5:0], nibble};
                    nib_cnt   <= nib_cnt + 1'b1;
                    if (nib_cnt == LAST) begin
                        block_valid <= 1'b1;
                        char_ready  <= 1'b0;
                        state       <= HOLD;
                    end
                end else if (take && !is_ws) begin
                    block_out <= '0;
                    nib_cnt   <= '0;
                    err       <= 1'b1;
                end
            end else if (block_ready) begin
                block_valid <= 1'b0;
                block_out   <= '0;
                nib_cnt     <= '0;
                char_ready  <= 1'b1;
                state       <= COLLECT;
            end
        end
    end
endmodule
